knight_move_feeder: RTL and testbench

Sequential front end for the knight move checker. On `start`, it scans the board RAM for knights of the side to move. For each knight found, it emits exactly eight `{src_piece, dest_piece}` pairs, one per knight offset, over a valid/ready handshake; the checker consumes the pairs combinationally. Off-board targets are emitted with type INVALID, so the checker rejects them without any special case.

---
 rtl/knight_move_feeder_pkg.sv | 34 +++
 rtl/knight_move_feeder_if.sv | 26 ++
 rtl/knight_move_feeder_offset_rom.sv | 23 ++
 rtl/knight_move_feeder.sv | 143 ++++++++++++++
 tb/tb_knight_move_feeder.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/knight_move_feeder_pkg.sv
// Shared move-checker constants: piece type codes, the packed piece layout and
// the feeder FSM state encoding.
package knight_move_feeder_pkg;

    localparam logic [2:0] EMPTY   = 3'd0;
    localparam logic [2:0] PAWN    = 3'd1;
    localparam logic [2:0] KNIGHT  = 3'd2;
    localparam logic [2:0] BISHOP  = 3'd3;
    localparam logic [2:0] ROOK    = 3'd4;
    localparam logic [2:0] QUEEN   = 3'd5;
    localparam logic [2:0] KING    = 3'd6;
    localparam logic [2:0] INVALID = 3'd7;

    localparam logic [5:0] LAST_SQ = 6'd63;
    localparam logic [2:0] LAST_K  = 3'd7;

    typedef struct packed {
        logic [2:0] ptype;
        logic [2:0] col;
        logic [2:0] row;
        logic       color;
    } piece_t;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_SCAN     = 3'd1,
        S_SCAN_CHK = 3'd2,
        S_OFF      = 3'd3,
        S_OFF_RD   = 3'd4,
        S_EMIT     = 3'd5,
        S_DONE     = 3'd6
    } state_t;

endpackage

// File: rtl/knight_move_feeder_if.sv
// Board RAM read port plus the pair stream from the feeder to the knight checker.
interface knight_move_feeder_if;
    import knight_move_feeder_pkg::*;

    logic       board_rd_en;
    logic [5:0] board_addr;
    logic [3:0] board_data;

    // Pair stream: a pair transfers on a cycle with pair_valid && pair_ready;
    // once raised, pair_valid and both pieces hold until that transfer happens.
    logic       pair_valid;
    logic       pair_ready;
    piece_t     src_piece;
    piece_t     dest_piece;

    modport master (
        output board_rd_en, board_addr, pair_valid, src_piece, dest_piece,
        input  board_data, pair_ready
    );

    modport slave (
        input  board_rd_en, board_addr, pair_valid, src_piece, dest_piece,
        output board_data, pair_ready
    );

endinterface

// File: rtl/knight_move_feeder_offset_rom.sv
// Combinational table of the eight knight jumps, indexed clockwise from (+1,+2).
module knight_move_feeder_offset_rom (
    input  logic        [2:0] k,
    output logic signed [3:0] dcol,
    output logic signed [3:0] drow
);

    always_comb begin
        dcol = '0;
        drow = '0;
        case (k)
            3'd0: begin dcol =  4'sd1; drow =  4'sd2; end
            3'd1: begin dcol =  4'sd2; drow =  4'sd1; end
            3'd2: begin dcol =  4'sd2; drow = -4'sd1; end
            3'd3: begin dcol =  4'sd1; drow = -4'sd2; end
            3'd4: begin dcol = -4'sd1; drow = -4'sd2; end
            3'd5: begin dcol = -4'sd2; drow = -4'sd1; end
            3'd6: begin dcol = -4'sd2; drow =  4'sd1; end
            default: begin dcol = -4'sd1; drow = 4'sd2; end
        endcase
    end

endmodule

// File: rtl/knight_move_feeder.sv
// Scans the board for knights of the side to move and streams eight
// {src, dest} pairs per knight; off-board targets are tagged INVALID.
module knight_move_feeder
    import knight_move_feeder_pkg::*;
#(
    parameter int RD_LAT = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                turn,
    knight_move_feeder_if.master bus,
    output logic                busy,
    output logic                done,
    output state_t              dbg_state
);

    if (RD_LAT != 1) begin : g_rd_lat_check
        $error("knight_move_feeder: only RD_LAT = 1 is supported");
    end

    state_t            r_state;
    state_t            w_next;
    logic        [5:0] r_sq;
    logic        [2:0] r_k;
    logic              r_turn;
    piece_t            r_src;
    piece_t            r_dest;

    logic signed [3:0] w_dcol;
    logic signed [3:0] w_drow;
    logic        [3:0] w_tc;
    logic        [3:0] w_tr;
    logic              w_on_board;
    logic              w_own_knight;
    logic              w_rd_en;
    logic        [5:0] w_addr;

    knight_move_feeder_offset_rom u_rom (
        .k    (r_k),
        .dcol (w_dcol),
        .drow (w_drow)
    );

    // 4-bit sums span -2..9; bit 3 set means below 0 or above 7.
    assign w_tc         = {1'b0, r_src.col} + $unsigned(w_dcol);
    assign w_tr         = {1'b0, r_src.row} + $unsigned(w_drow);
    assign w_on_board   = !w_tc[3] && !w_tr[3];
    assign w_own_knight = (bus.board_data[3:1] == KNIGHT) && (bus.board_data[0] == r_turn);

    always_comb begin
        w_next  = r_state;
        w_rd_en = 1'b0;
        w_addr  = '0;
        case (r_state)
            S_IDLE: begin
                if (start) w_next = S_SCAN;
            end
            S_SCAN: begin
                w_rd_en = 1'b1;
                w_addr  = r_sq;
                w_next  = S_SCAN_CHK;
            end
            S_SCAN_CHK: begin
                if (w_own_knight)        w_next = S_OFF;
                else if (r_sq == LAST_SQ) w_next = S_DONE;
                else                      w_next = S_SCAN;
            end
            S_OFF: begin
                if (w_on_board) begin
                    w_rd_en = 1'b1;
                    w_addr  = {w_tc[2:0], w_tr[2:0]};
                    w_next  = S_OFF_RD;
                end else begin
                    w_next  = S_EMIT;
                end
            end
            S_OFF_RD: w_next = S_EMIT;
            S_EMIT: begin
                if (bus.pair_ready) begin
                    if (r_k != LAST_K)        w_next = S_OFF;
                    else if (r_sq == LAST_SQ) w_next = S_DONE;
                    else                      w_next = S_SCAN;
                end
            end
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_sq    <= '0;
            r_k     <= '0;
            r_turn  <= 1'b0;
            r_src   <= '0;
            r_dest  <= '0;
        end else begin
            r_state <= w_next;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_turn <= turn;
                        r_sq   <= '0;
                    end
                end
                S_SCAN_CHK: begin
                    if (w_own_knight) begin
                        r_src <= piece_t'{KNIGHT, r_sq[5:3], r_sq[2:0], bus.board_data[0]};
                        r_k   <= '0;
                    end else if (r_sq != LAST_SQ) begin
                        r_sq  <= r_sq + 6'd1;
                    end
                end
                S_OFF: begin
                    if (!w_on_board)
                        r_dest <= piece_t'{INVALID, w_tc[2:0], w_tr[2:0], 1'b0};
                end
                S_OFF_RD: begin
                    r_dest <= piece_t'{bus.board_data[3:1], w_tc[2:0], w_tr[2:0], bus.board_data[0]};
                end
                S_EMIT: begin
                    if (bus.pair_ready) begin
                        if (r_k != LAST_K)        r_k  <= r_k + 3'd1;
                        else if (r_sq != LAST_SQ) r_sq <= r_sq + 6'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.board_rd_en = w_rd_en;
    assign bus.board_addr  = w_addr;
    assign bus.pair_valid  = (r_state == S_EMIT);
    assign bus.src_piece   = r_src;
    assign bus.dest_piece  = r_dest;
    assign busy            = (r_state != S_IDLE);
    assign done            = (r_state == S_DONE);
    assign dbg_state       = r_state;

endmodule

// File: tb/tb_knight_move_feeder.sv
// Directed bench for knight_move_feeder: board RAM model, pair collection and
// hand-computed expected pairs and latencies.
module tb_knight_move_feeder;
    import knight_move_feeder_pkg::*;

    logic   clk   = 1'b0;
    logic   rst_n = 1'b0;
    logic   start = 1'b0;
    logic   turn  = 1'b0;
    logic   busy;
    logic   done;
    state_t dbg_state;

    int n_checks = 0;
    int n_fail   = 0;

    knight_move_feeder_if bus ();

    knight_move_feeder #(.RD_LAT(1)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .turn      (turn),
        .bus       (bus.master),
        .busy      (busy),
        .done      (done),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    // Board RAM, one-cycle read latency
    logic [3:0] mem [64];
    always @(posedge clk) begin
        if (bus.board_rd_en) bus.board_data <= mem[bus.board_addr];
    end

    logic [5:0] addr_q [$];
    always @(posedge clk) begin
        if (bus.board_rd_en) addr_q.push_back(bus.board_addr);
    end

    piece_t got_src  [$];
    piece_t got_dest [$];
    piece_t exp_b1   [8];
    piece_t exp_d4   [8];

    function automatic piece_t pc(input logic [2:0] t, input int c, input int r, input logic col);
        piece_t p;
        p.ptype = t;
        p.col   = 3'(c);
        p.row   = 3'(r);
        p.color = col;
        return p;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_board();
        for (int i = 0; i < 64; i++) mem[i] = 4'h0;
    endtask

    // Pulses start, flips turn afterwards, collects accepted pairs and returns
    // the cycle (counted from the sampling edge) in which done is seen, or -1.
    task automatic run_scan(input logic t, output int cycles);
        got_src.delete();
        got_dest.delete();
        @(negedge clk);
        start = 1'b1;
        turn  = t;
        @(negedge clk);
        start  = 1'b0;
        turn   = ~t;
        cycles = 1;
        while (!done && cycles < 400) begin
            if (bus.pair_valid && bus.pair_ready) begin
                got_src.push_back(bus.src_piece);
                got_dest.push_back(bus.dest_piece);
            end
            @(negedge clk);
            cycles++;
        end
        if (!done) cycles = -1;
    endtask

    task automatic wait_valid(input string tag);
        int n;
        n = 0;
        while (!bus.pair_valid && n < 400) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(bus.pair_valid), 32'd1);
    endtask

    task automatic check_pairs(input string tag, input piece_t src, input piece_t dst [8]);
        check({tag, " pair_count"}, 32'(got_src.size()), 32'd8);
        for (int i = 0; i < 8 && i < got_src.size(); i++) begin
            check($sformatf("%s src k%0d", tag, i), 32'(got_src[i]), 32'(src));
            check($sformatf("%s dest k%0d", tag, i), 32'(got_dest[i]), 32'(dst[i]));
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, " pair_valid"}, 32'(bus.pair_valid), 32'd0);
        check({tag, " busy"}, 32'(busy), 32'd0);
        check({tag, " done"}, 32'(done), 32'd0);
        check({tag, " rd_en"}, 32'(bus.board_rd_en), 32'd0);
        check({tag, " addr"}, 32'(bus.board_addr), 32'd0);
        check({tag, " src"}, 32'(bus.src_piece), 32'd0);
        check({tag, " dest"}, 32'(bus.dest_piece), 32'd0);
        check({tag, " state"}, 32'(dbg_state), 32'(S_IDLE));
    endtask

    initial begin
        int cyc;
        bus.board_data = 4'h0;
        bus.pair_ready = 1'b1;
        clear_board();

        exp_b1[0] = pc(EMPTY,   2, 2, 1'b0);
        exp_b1[1] = pc(EMPTY,   3, 1, 1'b0);
        exp_b1[2] = pc(INVALID, 3, 7, 1'b0);
        exp_b1[3] = pc(INVALID, 2, 6, 1'b0);
        exp_b1[4] = pc(INVALID, 0, 6, 1'b0);
        exp_b1[5] = pc(INVALID, 7, 7, 1'b0);
        exp_b1[6] = pc(INVALID, 7, 1, 1'b0);
        exp_b1[7] = pc(EMPTY,   0, 2, 1'b0);

        exp_d4[0] = pc(PAWN,  4, 5, 1'b0);
        exp_d4[1] = pc(PAWN,  5, 4, 1'b1);
        exp_d4[2] = pc(EMPTY, 5, 2, 1'b0);
        exp_d4[3] = pc(EMPTY, 4, 1, 1'b0);
        exp_d4[4] = pc(EMPTY, 2, 1, 1'b0);
        exp_d4[5] = pc(EMPTY, 1, 2, 1'b0);
        exp_d4[6] = pc(EMPTY, 1, 4, 1'b0);
        exp_d4[7] = pc(EMPTY, 2, 5, 1'b0);

        // Reset state
        repeat (2) @(negedge clk);
        check_idle_outputs("reset");
        rst_n = 1'b1;

        // Empty board: 64 in-order reads, done in cycle 129, no pairs
        addr_q.delete();
        run_scan(1'b0, cyc);
        check("empty done_cycle", 32'(cyc), 32'd129);
        check("empty pair_count", 32'(got_src.size()), 32'd0);
        check("empty read_count", 32'(addr_q.size()), 32'd64);
        for (int i = 0; i < 64 && i < addr_q.size(); i++)
            check($sformatf("empty addr%0d", i), 32'(addr_q[i]), 32'(i));
        @(negedge clk);
        check("empty done_pulse", 32'(done), 32'd0);
        check("empty busy_after", 32'(busy), 32'd0);

        // White knight at b1, white to move
        mem[8] = {KNIGHT, 1'b0};
        run_scan(1'b0, cyc);
        check("b1w done_cycle", 32'(cyc), 32'd148);
        check_pairs("b1w", pc(KNIGHT, 1, 0, 1'b0), exp_b1);

        // Black knight at b1: ignored with white to move, scanned with black
        mem[8] = {KNIGHT, 1'b1};
        run_scan(1'b0, cyc);
        check("b1b_w done_cycle", 32'(cyc), 32'd129);
        check("b1b_w pair_count", 32'(got_src.size()), 32'd0);
        run_scan(1'b1, cyc);
        check("b1b_b done_cycle", 32'(cyc), 32'd148);
        check_pairs("b1b_b", pc(KNIGHT, 1, 0, 1'b1), exp_b1);

        // Knight d4 with own pawn e6 and enemy pawn f5
        clear_board();
        mem[27] = {KNIGHT, 1'b0};
        mem[37] = {PAWN, 1'b0};
        mem[44] = {PAWN, 1'b1};
        run_scan(1'b0, cyc);
        check("d4 done_cycle", 32'(cyc), 32'd153);
        check_pairs("d4", pc(KNIGHT, 3, 3, 1'b0), exp_d4);

        // Backpressure at k=3, then reset while holding the k=4 pair
        @(negedge clk);
        start = 1'b1;
        turn  = 1'b0;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            wait_valid($sformatf("stall pre%0d", i));
            @(negedge clk);
        end
        wait_valid("stall k3 valid");
        check("stall k3 dest", 32'(bus.dest_piece), 32'(exp_d4[3]));
        bus.pair_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check($sformatf("stall hold%0d valid", i), 32'(bus.pair_valid), 32'd1);
            check($sformatf("stall hold%0d src", i), 32'(bus.src_piece), 32'(pc(KNIGHT, 3, 3, 1'b0)));
            check($sformatf("stall hold%0d dest", i), 32'(bus.dest_piece), 32'(exp_d4[3]));
        end
        bus.pair_ready = 1'b1;
        @(negedge clk);
        check("stall release valid", 32'(bus.pair_valid), 32'd0);
        check("stall release state", 32'(dbg_state), 32'(S_OFF));
        wait_valid("stall k4 valid");
        check("stall k4 dest", 32'(bus.dest_piece), 32'(exp_d4[4]));
        check("stall k4 state", 32'(dbg_state), 32'(S_EMIT));
        rst_n = 1'b0;
        @(negedge clk);
        check_idle_outputs("midreset");
        rst_n = 1'b1;

        // Fresh scan after reset restarts at square 0
        addr_q.delete();
        run_scan(1'b0, cyc);
        check("rescan first_addr", 32'(addr_q.size() > 0 ? addr_q[0] : 6'h3f), 32'd0);
        check("rescan done_cycle", 32'(cyc), 32'd153);
        check_pairs("rescan", pc(KNIGHT, 3, 3, 1'b0), exp_d4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
